// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, LSB-first frames of 5..16 data bits with
// optional even/odd parity and one or two stop bits. Frame settings are
// captured when a frame is accepted so the register interface can change
// freely while the frame is on the line.
module uart_tx #(
    parameter int DIV_W  = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    input  logic [4:0]        bits_per_word,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              two_stop_bit,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
    localparam logic [4:0]       IDX_MAX  = 5'd15;

    state_t              state_q, state_d;

    // Baud counter runs 1..D inside a frame and holds at zero outside it.
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;

    // Shadow copies of the frame settings, captured on acceptance.
    logic [DIV_W-1:0]    div_q, div_d;
    logic [4:0]          last_q, last_d;
    logic                par_en_q, par_en_d;
    logic                par_odd_q, par_odd_d;
    logic                two_stop_q, two_stop_d;

    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                bit_end;

    assign bit_end = (cnt_q == div_q);

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    // State, datapath and registered outputs; reset aborts any frame at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            div_q      <= '0;
            last_q     <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            div_q      <= div_d;
            last_q     <= last_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: frame sequencing, bit timing and setting capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        div_d      = div_q;
        last_d     = last_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;

        // Inside a frame the counter either advances or reloads at bit end.
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? CNT_ONE : (cnt_q + CNT_ONE);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_START;
                    cnt_d      = CNT_ONE;
                    idx_d      = '0;
                    par_d      = 1'b0;
                    shift_d    = data_in;
                    // A divisor of zero behaves as one clock per bit.
                    div_d      = (clk_div == '0) ? CNT_ONE : clk_div;
                    last_d     = (bits_per_word > IDX_MAX) ? IDX_MAX : bits_per_word;
                    par_en_d   = parity_en;
                    par_odd_d  = parity_odd;
                    two_stop_d = two_stop_bit;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    // Running parity covers exactly the bits actually sent.
                    par_d = par_q ^ shift_q[0];
                    if (idx_q == last_q) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (bit_end) begin
                    state_d = two_stop_q ? S_STOP2 : S_IDLE;
                end
            end
            S_STOP2: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving a frame parks the counter so no tick runs while idle.
        if (state_d == S_IDLE) begin
            cnt_d = '0;
        end
    end

    // Output logic: line level and status for the state being entered.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_IDLE) &&
                 ((state_q == S_STOP1) || (state_q == S_STOP2));

        unique case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d ^ par_odd_q;
            S_STOP1:  tx_d = 1'b1;
            S_STOP2:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

endmodule
